bk_pipe_subtractor: RTL and testbench



---
 rtl/bk_pipe_subtractor_if.sv | 51 +++++
 rtl/bk_pipe_subtractor.sv | 206 ++++++++++++++++++++
 tb/tb_bk_pipe_subtractor.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bk_pipe_subtractor_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bk_pipe_subtractor_if                                           |
// | Purpose  : Streaming bundle for the pipelined Brent-Kung subtractor.       |
// |            Carries the operand beat (valid/ready, interleaved operands,    |
// |            borrow-in) and the result beat (valid/ready, difference,        |
// |            borrow-out, zero flag).                                         |
// | Signals  : in_valid, in_ready, in_operands[2*WIDTH], in_borrow,            |
// |            out_valid, out_ready, out_diff[WIDTH], out_borrow, out_zero     |
// | Modports : master - producer of operands / consumer of results            |
// |            slave  - the subtractor itself                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface bk_pipe_subtractor_if #(
  parameter int WIDTH = 12
);
  logic               in_valid;
  logic               in_ready;
  logic [2*WIDTH-1:0] in_operands;
  logic               in_borrow;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_diff;
  logic               out_borrow;
  logic               out_zero;

  modport master (
    output in_valid,
    output in_operands,
    output in_borrow,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_diff,
    input  out_borrow,
    input  out_zero
  );

  modport slave (
    input  in_valid,
    input  in_operands,
    input  in_borrow,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_diff,
    output out_borrow,
    output out_zero
  );
endinterface
`default_nettype wire

// File: rtl/bk_pipe_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bk_pipe_subtractor                                              |
// | Purpose  : Three-stage, valid/ready pipelined unsigned subtractor computing|
// |            a - b - borrow_in as a + ~b + ~borrow_in on a Brent-Kung prefix |
// |            network.                                                        |
// |              S1: unpack operands, register per-bit generate/propagate and  |
// |                  the borrow-in.                                            |
// |              S2: Brent-Kung up-sweep, register group terms + bit propagate.|
// |              S3: down-sweep, sum = p ^ carry, register diff/borrow/zero.   |
// | Ports    : clk     - rising-edge clock                                     |
// |            rst_n   - asynchronous active-low reset                         |
// |            bus     - bk_pipe_subtractor_if.slave                           |
// |                      in_valid/in_ready/in_operands/in_borrow  (operands)   |
// |                      out_valid/out_ready/out_diff/out_borrow/out_zero      |
// | Params   : WIDTH   - operand width, even and >= 2                          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module bk_pipe_subtractor #(
  parameter int WIDTH = 12
) (
  input wire                  clk,
  input wire                  rst_n,
  bk_pipe_subtractor_if.slave bus
);

  localparam int LEVELS = $clog2(WIDTH);

  if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
    $error("bk_pipe_subtractor: WIDTH must be even and >= 2");
  end

  // --------------------------------------------------------------------------
  // Flow control: each stage may accept when empty or when the stage after it
  // is draining this cycle. in_ready is therefore combinational from out_ready.
  // --------------------------------------------------------------------------
  logic r_s1_valid;
  logic r_s2_valid;
  logic r_s3_valid;
  logic w_ready1;
  logic w_ready2;
  logic w_ready3;
  logic w_load1;
  logic w_load2;
  logic w_load3;

  assign w_ready3 = ~r_s3_valid | bus.out_ready;
  assign w_ready2 = ~r_s2_valid | w_ready3;
  assign w_ready1 = ~r_s1_valid | w_ready2;

  assign w_load1  = bus.in_valid & w_ready1;
  assign w_load2  = r_s1_valid   & w_ready2;
  assign w_load3  = r_s2_valid   & w_ready3;

  assign bus.in_ready = w_ready1;

  // A stage's valid follows its upstream valid whenever it is ready: it either
  // takes a new beat or, having handed its own beat on, empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s3_valid <= 1'b0;
    end else begin
      if (w_ready1) r_s1_valid <= bus.in_valid;
      if (w_ready2) r_s2_valid <= r_s1_valid;
      if (w_ready3) r_s3_valid <= r_s2_valid;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1: unpack interleaved operands, per-bit generate/propagate of a + ~b.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_unpack
    assign w_a[gi] = bus.in_operands[2*gi];
    assign w_b[gi] = bus.in_operands[2*gi+1];
  end

  assign w_g = w_a & ~w_b;
  assign w_p = w_a ^ ~w_b;

  logic [WIDTH-1:0] r_s1_g;
  logic [WIDTH-1:0] r_s1_p;
  logic             r_s1_borrow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_g      <= '0;
      r_s1_p      <= '0;
      r_s1_borrow <= 1'b0;
    end else if (w_load1) begin
      r_s1_g      <= w_g;
      r_s1_p      <= w_p;
      r_s1_borrow <= bus.in_borrow;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: Brent-Kung up-sweep.
  // The carry-in of the adder form (~borrow_in) is folded into bit 0's
  // generate so every prefix computed below is a true carry out of its bit.
  // At level l, every position i with (i+1) a multiple of 2^(l+1) absorbs the
  // group ending at i - 2^l; that source position is never rewritten at the
  // same level, so the update can be done in place.
  // --------------------------------------------------------------------------
  logic             w_s2_cin;
  logic [WIDTH-1:0] w_up_g;
  logic [WIDTH-1:0] w_up_p;

  assign w_s2_cin = ~r_s1_borrow;

  always_comb begin
    w_up_g    = r_s1_g;
    w_up_p    = r_s1_p;
    w_up_g[0] = r_s1_g[0] | (r_s1_p[0] & w_s2_cin);
    for (int l = 0; l < LEVELS; l++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (((i + 1) % (2 << l)) == 0) begin
          w_up_g[i] = w_up_g[i] | (w_up_p[i] & w_up_g[i - (1 << l)]);
          w_up_p[i] = w_up_p[i] & w_up_p[i - (1 << l)];
        end
      end
    end
  end

  logic [WIDTH-1:0] r_s2_gg;
  logic [WIDTH-1:0] r_s2_gp;
  logic [WIDTH-1:0] r_s2_p;
  logic             r_s2_cin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_gg  <= '0;
      r_s2_gp  <= '0;
      r_s2_p   <= '0;
      r_s2_cin <= 1'b0;
    end else if (w_load2) begin
      r_s2_gg  <= w_up_g;
      r_s2_gp  <= w_up_p;
      r_s2_p   <= r_s1_p;
      r_s2_cin <= w_s2_cin;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 3: Brent-Kung down-sweep.
  // Working from the widest span down, position i with (i+1) mod 2^(l+1) equal
  // to 2^l (and a non-empty left neighbour) joins the full prefix at i - 2^l,
  // which the up-sweep or a wider down-sweep level has already completed.
  // Because the carry-in is folded into bit 0, only generate needs updating.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] w_dn_g;

  always_comb begin
    w_dn_g = r_s2_gg;
    for (int l = LEVELS - 1; l >= 0; l--) begin
      for (int i = 0; i < WIDTH; i++) begin
        if ((((i + 1) % (2 << l)) == (1 << l)) && (i > (1 << l))) begin
          w_dn_g[i] = w_dn_g[i] | (r_s2_gp[i] & w_dn_g[i - (1 << l)]);
        end
      end
    end
  end

  // Group propagate at positions that already hold full prefixes is not
  // consumed by the down-sweep.
  logic w_unused_gp;
  assign w_unused_gp = &{1'b0, r_s2_gp};

  logic [WIDTH-1:0] w_carry;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;

  assign w_carry = {w_dn_g[WIDTH-2:0], r_s2_cin};
  assign w_sum   = r_s2_p ^ w_carry;
  assign w_cout  = w_dn_g[WIDTH-1];

  logic [WIDTH-1:0] r_s3_diff;
  logic             r_s3_borrow;
  logic             r_s3_zero;

  // A missing carry-out of a + ~b + ~borrow_in means the subtraction borrowed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s3_diff   <= '0;
      r_s3_borrow <= 1'b0;
      r_s3_zero   <= 1'b0;
    end else if (w_load3) begin
      r_s3_diff   <= w_sum;
      r_s3_borrow <= ~w_cout;
      r_s3_zero   <= ~|w_sum;
    end
  end

  assign bus.out_valid  = r_s3_valid;
  assign bus.out_diff   = r_s3_diff;
  assign bus.out_borrow = r_s3_borrow;
  assign bus.out_zero   = r_s3_zero;

endmodule
`default_nettype wire

// File: tb/tb_bk_pipe_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_bk_pipe_subtractor                                           |
// | Purpose  : Self-checking bench for bk_pipe_subtractor (WIDTH=12). Expected |
// |            results come from a reference a - b - borrow_in model, queued  |
// |            on acceptance and compared when the DUT emits a result.        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_bk_pipe_subtractor;

  localparam int W = 12;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         borrow;
    logic         zero;
  } exp_t;

  logic clk;
  logic rst_n;

  bk_pipe_subtractor_if #(.WIDTH(W)) bus ();

  bk_pipe_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_tests;
  int           n_fail;
  int           n_acc;
  int           cyc;
  exp_t         sb[$];
  int           pop_cyc[$];
  logic [W-1:0] pop_diff[$];
  logic         pop_brw[$];
  logic [W-1:0] cur_a;
  logic [W-1:0] cur_b;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    logic [W:0] full;
    exp_t       e;
    full     = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
    e.diff   = full[W-1:0];
    e.borrow = full[W];
    e.zero   = (full[W-1:0] == '0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    bus.in_valid  = v;
    bus.in_borrow = bi;
    cur_a         = a;
    cur_b         = b;
    for (int i = 0; i < W; i++) begin
      bus.in_operands[2*i]   = a[i];
      bus.in_operands[2*i+1] = b[i];
    end
  endtask

  // Called at a falling edge with inputs already driven: settles, records
  // handshakes as they will happen at the next rising edge, then advances.
  task automatic drive();
    exp_t e;
    #1;
    if (bus.in_valid && bus.in_ready) begin
      sb.push_back(model(cur_a, cur_b, bus.in_borrow));
      n_acc++;
    end
    if (bus.out_valid && bus.out_ready) begin
      pop_cyc.push_back(cyc);
      pop_diff.push_back(bus.out_diff);
      pop_brw.push_back(bus.out_borrow);
      chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_diff",   32'(bus.out_diff),   32'(e.diff));
        chk("sb_borrow", 32'(bus.out_borrow), 32'(e.borrow));
        chk("sb_zero",   32'(bus.out_zero),   32'(e.zero));
      end
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  // One beat with out_ready high. Counting the accepting edge as the first,
  // the result must appear right after the third rising edge.
  task automatic single(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bi, input logic [W-1:0] ed, input logic eb, input logic ez);
    bus.out_ready = 1'b1;
    set_in(1'b1, a, b, bi);
    #1;
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    drive();
    set_in(1'b0, '0, '0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      #1;
      if (k < 3) begin
        chk({tag, "_early_valid"}, 32'(bus.out_valid), 32'd0);
      end else begin
        chk({tag, "_valid"},  32'(bus.out_valid),  32'd1);
        chk({tag, "_diff"},   32'(bus.out_diff),   32'(ed));
        chk({tag, "_borrow"}, 32'(bus.out_borrow), 32'(eb));
        chk({tag, "_zero"},   32'(bus.out_zero),   32'(ez));
      end
      drive();
    end
  endtask

  initial begin
    logic [W-1:0] bb_a   [4];
    logic [W-1:0] bb_b   [4];
    logic [W-1:0] bb_exp [4];
    logic         bb_brw [4];
    int           start;
    int           guard;

    n_tests = 0;
    n_fail  = 0;
    n_acc   = 0;
    cyc     = 0;
    rst_n   = 1'b0;
    bus.out_ready = 1'b0;
    set_in(1'b0, '0, '0, 1'b0);

    // ---- reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid",  32'(bus.out_valid),  32'd0);
    chk("rst_out_diff",   32'(bus.out_diff),   32'd0);
    chk("rst_out_borrow", 32'(bus.out_borrow), 32'd0);
    chk("rst_out_zero",   32'(bus.out_zero),   32'd0);
    chk("rst_in_ready",   32'(bus.in_ready),   32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ---- single beats, latency and arithmetic corners
    single("t_0m1",    12'h000, 12'h001, 1'b0, 12'hFFF, 1'b1, 1'b0);
    single("t_800m1",  12'h800, 12'h001, 1'b0, 12'h7FF, 1'b0, 1'b0);
    single("t_eq",     12'h5A5, 12'h5A5, 1'b0, 12'h000, 1'b0, 1'b1);
    single("t_eq_bin", 12'h5A5, 12'h5A5, 1'b1, 12'hFFF, 1'b1, 1'b0);

    // ---- four back-to-back beats, results on consecutive cycles
    bb_a   = '{12'h010, 12'h100, 12'hFFF, 12'h001};
    bb_b   = '{12'h001, 12'h010, 12'hFFF, 12'h002};
    bb_exp = '{12'h00F, 12'h0F0, 12'h000, 12'hFFF};
    bb_brw = '{1'b0, 1'b0, 1'b0, 1'b1};
    pop_cyc.delete();
    pop_diff.delete();
    pop_brw.delete();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, bb_a[i], bb_b[i], 1'b0);
      #1;
      chk("bb_in_ready", 32'(bus.in_ready), 32'd1);
      drive();
    end
    set_in(1'b0, '0, '0, 1'b0);
    repeat (4) drive();
    chk("bb_count", 32'(pop_diff.size()), 32'd4);
    if (pop_diff.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("bb_diff",   32'(pop_diff[i]), 32'(bb_exp[i]));
        chk("bb_borrow", 32'(pop_brw[i]),  32'(bb_brw[i]));
        if (i > 0) chk("bb_consecutive", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd1);
      end
    end

    // ---- stall: out_ready low for 6 cycles, only 3 beats fit
    pop_cyc.delete();
    bus.out_ready = 1'b0;
    start = n_acc;
    for (int i = 0; i < 6; i++) begin
      set_in(1'b1, 12'($urandom), 12'($urandom), 1'($urandom));
      drive();
      if (i >= 2) begin
        chk("stall_valid",  32'(bus.out_valid),  32'd1);
        chk("stall_diff",   32'(bus.out_diff),   32'(sb[0].diff));
        chk("stall_borrow", 32'(bus.out_borrow), 32'(sb[0].borrow));
        chk("stall_zero",   32'(bus.out_zero),   32'(sb[0].zero));
      end
    end
    #1;
    chk("stall_accepted", 32'(n_acc - start), 32'd3);
    chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
    set_in(1'b0, '0, '0, 1'b0);
    bus.out_ready = 1'b1;
    repeat (5) drive();
    chk("stall_drained", 32'(pop_cyc.size()), 32'd3);
    chk("stall_sb_empty", 32'(sb.size()), 32'd0);

    // ---- random traffic
    start = n_acc;
    guard = 0;
    while (((n_acc - start) < 10000) && (guard < 60000)) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      set_in($urandom_range(0, 3) != 0, 12'($urandom), 12'($urandom), 1'($urandom));
      drive();
      guard++;
    end
    chk("rand_accepted", 32'(n_acc - start), 32'd10000);
    set_in(1'b0, '0, '0, 1'b0);
    bus.out_ready = 1'b1;
    repeat (6) drive();
    chk("rand_sb_empty", 32'(sb.size()), 32'd0);

    // ---- asynchronous reset with beats in flight
    bus.out_ready = 1'b0;
    set_in(1'b1, 12'h123, 12'h045, 1'b0);
    drive();
    set_in(1'b1, 12'h456, 12'h789, 1'b1);
    drive();
    set_in(1'b0, '0, '0, 1'b0);
    drive();
    #1;
    chk("arst_pre_valid", 32'(bus.out_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid",  32'(bus.out_valid),  32'd0);
    chk("arst_diff",   32'(bus.out_diff),   32'd0);
    chk("arst_borrow", 32'(bus.out_borrow), 32'd0);
    chk("arst_zero",   32'(bus.out_zero),   32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("arst_no_stale", 32'(bus.out_valid), 32'd0);
      drive();
    end
    single("t_post_rst", 12'h234, 12'h034, 1'b1, 12'h1FF, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
